// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames UART bytes into sync/len/payload/cksum packets.
// Optional inter-byte timeout enabled by UART_RX_PKT_CTRL_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       pkt_ready,
  output logic [7:0] pkt_len,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       pkt_ack,
  output logic       busy,
  output logic       err_cksum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       overrun
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAY,
    S_CK,
    S_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] acc_q, acc_d;
  logic       wr_en;
  logic       ck_err_d, len_err_d, ovr_d;
  logic       to_hit;
  logic [7:0] rd_q;
  logic [7:0] mem [MAX_LEN];

  assign busy      = (state_q == S_LEN) || (state_q == S_PAY)
                  || (state_q == S_CK);
  assign pkt_ready = (state_q == S_HOLD);
  assign pkt_len   = pkt_ready ? len_q : 8'd0;
  assign rd_data   = rd_q;

`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q;
  logic          to_err_q;

  // a byte in the expiry cycle wins, so rx_valid masks the hit
  assign to_hit = busy && !rx_valid && (to_cnt_q == TO_LAST);
  assign err_timeout = to_err_q;

  // idle-cycle counter, live only while a packet is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= to_hit;
      if (!busy || rx_valid || to_hit)
        to_cnt_q <= '0;
      else
        to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    wr_en     = 1'b0;
    ck_err_d  = 1'b0;
    len_err_d = 1'b0;
    ovr_d     = 1'b0;
    if (to_hit) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE))
            state_d = S_LEN;
        end
        S_LEN: begin
          if (rx_valid) begin
            if (rx_data > MAX_B) begin
              len_err_d = 1'b1;
              state_d   = S_IDLE;
            end else begin
              len_d   = rx_data;
              acc_d   = rx_data;
              idx_d   = 8'd0;
              state_d = (rx_data == 8'd0) ? S_CK : S_PAY;
            end
          end
        end
        S_PAY: begin
          if (rx_valid) begin
            wr_en = 1'b1;
            acc_d = acc_q + rx_data;
            idx_d = idx_q + 8'd1;
            if (idx_q == len_q - 8'd1)
              state_d = S_CK;
          end
        end
        S_CK: begin
          if (rx_valid) begin
            if (rx_data == acc_q) begin
              state_d = S_HOLD;
            end else begin
              ck_err_d = 1'b1;
              state_d  = S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (rx_valid)
            ovr_d = 1'b1;
          if (pkt_ack)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state, framing registers and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      acc_q     <= 8'd0;
      err_cksum <= 1'b0;
      err_len   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      err_cksum <= ck_err_d;
      err_len   <= len_err_d;
      overrun   <= ovr_d;
    end
  end

  // payload buffer write; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[idx_q[AW-1:0]] <= rx_data;
  end

  // registered host read, zero beyond the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_q <= 8'd0;
    else if (rd_addr < MAX_B)
      rd_q <= mem[rd_addr[AW-1:0]];
    else
      rd_q <= 8'd0;
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: directed packets with a scoreboard of expected events.
// Monitor pops one expected event for each DUT output event.
module tb_uart_rx_pkt_ctrl;

  localparam int EV_RD = 0;
  localparam int EV_CK = 1;
  localparam int EV_LN = 2;
  localparam int EV_TO = 3;
  localparam int EV_OV = 4;
  localparam int EV_UP = 5;
  localparam int EV_DN = 6;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       pkt_ready;
  logic [7:0] pkt_len;
  logic [7:0] rd_addr = 8'd0;
  logic [7:0] rd_data;
  logic       pkt_ack = 1'b0;
  logic       busy;
  logic       err_cksum;
  logic       err_len;
  logic       err_timeout;
  logic       overrun;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  logic rd_flag = 1'b0;
  logic rd_pend = 1'b0;
  logic prev_rdy = 1'b0;

  uart_rx_pkt_ctrl #(
    .MAX_LEN(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .pkt_ready(pkt_ready),
    .pkt_len(pkt_len),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .pkt_ack(pkt_ack),
    .busy(busy),
    .err_cksum(err_cksum),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_pend <= rd_flag;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int val);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected event kind %0d val %0h", kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL event got kind %0d val %0h want kind %0d val %0h",
                 kind, val, e.kind, e.val);
      end
    end
  endtask

  // monitor: every output event consumes one expected entry
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (rd_pend) observe(EV_RD, int'(rd_data));
      if (err_cksum) observe(EV_CK, 0);
      if (err_len) observe(EV_LN, 0);
      if (err_timeout) observe(EV_TO, 0);
      if (overrun) observe(EV_OV, 0);
      if (pkt_ready && !prev_rdy) observe(EV_UP, int'(pkt_len));
      if (!pkt_ready && prev_rdy) observe(EV_DN, 0);
      prev_rdy = pkt_ready;
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, input int exp);
    push(EV_RD, exp);
    rd_addr = a;
    rd_flag = 1'b1;
    @(posedge clk);
    #1 rd_flag = 1'b0;
  endtask

  task automatic ack();
    pkt_ack = 1'b1;
    @(posedge clk);
    #1 pkt_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #12;
    chk("reset_ready", int'(pkt_ready), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd", int'(rd_data), 0);
    rst_n = 1'b1;
    idle(1);

    // good packet, reads, out-of-range reads, ack
    send(8'hA5);
    chk("busy_len", int'(busy), 1);
    push(EV_UP, 3);
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    idle(1);
    chk("hold_busy", int'(busy), 0);
    rd(8'd0, 'h11);
    rd(8'd1, 'h22);
    rd(8'd2, 'h33);
    rd(8'd16, 'h00);
    rd(8'd200, 'h00);
    push(EV_DN, 0);
    ack();
    idle(2);
    chk("ack_len", int'(pkt_len), 0);

    // ack outside HOLD is ignored
    ack();
    idle(2);

    // bad checksum then good packet
    push(EV_CK, 0);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    idle(2);
    chk("ck_busy", int'(busy), 0);
    push(EV_UP, 1);
    send(8'hA5); send(8'h01); send(8'h7F); send(8'h80);
    idle(1);
    rd(8'd0, 'h7F);
    push(EV_DN, 0);
    ack();
    idle(2);

    // length too long, then zero-length packet
    push(EV_LN, 0);
    send(8'hA5); send(8'h11);
    idle(2);
    chk("len_busy", int'(busy), 0);
    push(EV_UP, 0);
    send(8'hA5); send(8'h00); send(8'h00);
    idle(1);
    push(EV_DN, 0);
    ack();
    idle(2);

    // full MAX_LEN packet 00..0F, checksum 10+78=88
    push(EV_UP, 16);
    send(8'hA5); send(8'h10);
    for (int i = 0; i < 16; i++) send(8'(i));
    send(8'h88);
    idle(1);
    rd(8'd15, 'h0F);
    rd(8'd0, 'h00);
    push(EV_DN, 0);
    ack();
    idle(2);

    // garbage before sync, overrun in HOLD, ack with byte
    push(EV_UP, 1);
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h01); send(8'h01); send(8'h02);
    idle(1);
    push(EV_OV, 0);
    send(8'h44);
    idle(1);
    rd(8'd0, 'h01);
    push(EV_OV, 0);
    push(EV_DN, 0);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    pkt_ack  = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    pkt_ack  = 1'b0;
    idle(2);
    chk("ovr_idle_busy", int'(busy), 0);

`ifdef UART_RX_PKT_CTRL_TIMEOUT_EN
    // stall of 100 idle cycles expires the packet
    push(EV_TO, 0);
    send(8'hA5); send(8'h02); send(8'hAA);
    idle(100);
    idle(2);
    chk("to_busy", int'(busy), 0);
    // byte arriving in the expiry cycle keeps the packet alive
    push(EV_UP, 2);
    send(8'hA5); send(8'h02); send(8'hAA);
    idle(99);
    send(8'hBB); send(8'h67);
    idle(1);
`else
    // without timeout a stalled packet simply waits
    push(EV_UP, 2);
    send(8'hA5); send(8'h02); send(8'hAA);
    idle(200);
    chk("stall_busy", int'(busy), 1);
    send(8'hBB); send(8'h67);
    idle(1);
`endif
    rd(8'd0, 'hAA);
    rd(8'd1, 'hBB);
    push(EV_DN, 0);
    ack();
    idle(2);

    // async reset in the middle of a payload
    send(8'hA5); send(8'h03); send(8'h01);
    chk("pre_rst_busy", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(pkt_ready), 0);
    chk("rst_len", int'(pkt_len), 0);
    chk("rst_rd", int'(rd_data), 0);
    chk("rst_errs", int'({err_cksum, err_len, err_timeout, overrun}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    push(EV_UP, 1);
    send(8'hA5); send(8'h01); send(8'h55); send(8'h56);
    idle(1);
    rd(8'd0, 'h55);
    idle(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
- Packet-level controller downstream of the UART byte receiver.
- Consumes the receiver's `data_rx`/`valid` byte stream and frames it into packets: sync byte, length, payload, checksum.
- Stores the payload in an internal buffer and holds it for a host-side reader until acknowledged.
- Reports framing, length and checksum errors as one-cycle pulses.

Parameters:
- MAX_LEN, 16, maximum payload bytes (1..255); sets buffer depth.
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYCLES, 50000, inter-byte timeout in clk cycles (≥2); used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle pulse, rx_data valid.
- pkt_ready  out  1  complete good packet held in buffer.
- pkt_len  out  8  payload length of held packet (0..MAX_LEN).
- rd_addr  in  8  buffer read address.
- rd_data  out  8  buffer read data, registered.
- pkt_ack  in  1  one-cycle pulse, host releases buffer.
- busy  out  1  high in LEN, PAYLOAD, CKSUM.
- err_cksum  out  1  pulse: checksum mismatch.
- err_len  out  1  pulse: length byte > MAX_LEN.
- err_timeout  out  1  pulse: inter-byte timeout.
- overrun  out  1  pulse: byte dropped while in HOLD.

Behaviour:
- Reset: rst_n low asynchronously forces IDLE; all outputs 0; byte index, length, checksum accumulator and timeout counter cleared. Buffer contents are not cleared. Reset mid-packet discards the partial packet.
- All state changes occur on rising clk. Bytes are processed only on cycles with rx_valid=1.
- IDLE:
  - rx_data==SYNC_BYTE -> LEN.
  - Any other byte is ignored with no error.
- LEN:
  - Byte >MAX_LEN -> err_len pulse next cycle, go to IDLE.
  - Otherwise latch length; checksum accumulator = byte.
  - Length 0 -> CKSUM; else -> PAYLOAD with index=0.
- PAYLOAD:
  - Write byte to buffer[index]; accumulator += byte (mod 256); index++.
  - When index reaches length-1 on a write -> CKSUM.
- CKSUM:
  - Byte == accumulator -> HOLD; pkt_ready=1 and pkt_len=length from the next cycle.
  - Mismatch -> err_cksum pulse, go to IDLE. Buffer contents are then undefined to the host.
- HOLD:
  - pkt_ready=1; pkt_len stable.
  - rx_valid -> byte dropped, overrun pulse next cycle.
  - pkt_ack -> IDLE; pkt_ready=0 the following cycle.
  - pkt_ack and rx_valid in the same cycle: byte dropped with overrun; state -> IDLE.
- pkt_ack outside HOLD is ignored.
- Error pulses are exactly one cycle; at most one error per cycle.
- Read port:
  - rd_data = buffer[rd_addr], registered, 1-cycle latency, readable in any state.
  - rd_addr ≥ MAX_LEN returns 8'h00.
  - Data is guaranteed only in HOLD for rd_addr < pkt_len.
- busy is combinationally decoded from state.
- Payload of a new packet overwrites the buffer; the host must read before pkt_ack.

Optional Feature:
- Macro: UART_RX_PKT_CTRL_TIMEOUT_EN.
- Defined:
  - In LEN, PAYLOAD and CKSUM, a counter increments each cycle without rx_valid and clears on rx_valid or state entry.
  - On reaching TIMEOUT_CYCLES-1 -> err_timeout pulse, go to IDLE, partial packet discarded.
  - rx_valid in the expiry cycle wins: the byte is processed and the counter clears.
  - No timeout in IDLE or HOLD.
- Undefined: no counter logic is synthesised; err_timeout is tied 0; an incomplete packet waits indefinitely.

Test Plan:
- Good packet: bytes A5 03 11 22 33 69 -> pkt_ready=1, pkt_len=3; reads of addr 0,1,2 return 11,22,33 one cycle after address; pkt_ack -> pkt_ready=0 next cycle, state IDLE.
- Bad checksum: A5 02 10 20 00 -> err_cksum single-cycle pulse, pkt_ready stays 0; a following good packet A5 01 7F 80 is accepted with pkt_len=1.
- Length check: A5 11 with MAX_LEN=16 -> err_len pulse, IDLE; A5 00 00 -> pkt_ready=1, pkt_len=0.
- Garbage and overrun: 00 FF 5A before A5 01 01 02 -> packet accepted; byte 44 sent during HOLD -> overrun pulse, buffer[0] still 01; simultaneous pkt_ack + rx_valid -> overrun and IDLE.
- Timeout (macro defined, TIMEOUT_CYCLES=100): A5 02 AA then 100 idle cycles -> err_timeout pulse, IDLE; byte arriving exactly at expiry -> no error, packet continues.
- Async reset: assert rst_n=0 mid-PAYLOAD without a clock edge -> outputs 0 immediately; after release, A5 01 55 56 -> pkt_ready=1.
